// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Memory-side responder for the MEM stage data port. Takes one load or
//   store request (byte, halfword or word), breaks it into single-byte
//   accesses on an 8-bit synchronous RAM, and returns extended load data
//   together with per-direction busy flags and a one-cycle finish strobe.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   read_i        : load op (001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU)
//   write_i       : store op (01 SB, 10 SH, 11 SW)
//   addr_i        : byte address (low ADDR_W bits used)
//   wdata_i       : store data, little-endian
//   read_busy_o   : load in progress
//   write_busy_o  : store in progress
//   read_data_o   : extended load result, held until the next load finishes
//   finish_o      : one-cycle completion strobe
//   mem_a_o       : RAM byte address
//   mem_wr_o      : RAM write enable
//   mem_dout_o    : RAM write byte
//   mem_din_i     : RAM read byte, one cycle after its address
module data_mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        read_i,
   input  logic [1:0]        write_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       wdata_i,
   output logic              read_busy_o,
   output logic              write_busy_o,
   output logic [31:0]       read_data_o,
   output logic              finish_o,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic              mem_wr_o,
   output logic [7:0]        mem_dout_o,
   input  logic [7:0]        mem_din_i
);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t            state;
   logic [2:0]        op_q;      // latched load op, selects extension
   logic [2:0]        len_q;     // bytes in the transfer (1, 2 or 4)
   logic [2:0]        cyc_q;     // cycles elapsed since the accepting edge
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rbuf_q;    // load bytes gathered so far
   logic [31:0]       cap_word;  // rbuf_q with this cycle's RAM byte merged in
   logic [2:0]        rd_len;
   logic [2:0]        wr_len;
   logic [1:0]        cap_idx;
   logic [2:0]        cyc_nxt;

   // Address bits above ADDR_W are intentionally discarded.
   logic unused_addr_hi;
   assign unused_addr_hi = ^addr_i[31:ADDR_W];

   function automatic logic [2:0] load_len(input logic [2:0] op);
      case (op)
         3'b001, 3'b100: load_len = 3'd1;
         3'b010, 3'b101: load_len = 3'd2;
         3'b011:         load_len = 3'd4;
         default:        load_len = 3'd0;  // none or reserved
      endcase
   endfunction

   function automatic logic [2:0] store_len(input logic [1:0] op);
      case (op)
         2'b01:   store_len = 3'd1;
         2'b10:   store_len = 3'd2;
         2'b11:   store_len = 3'd4;
         default: store_len = 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] w);
      case (op)
         3'b001:  extend = {{24{w[7]}}, w[7:0]};
         3'b010:  extend = {{16{w[15]}}, w[15:0]};
         3'b100:  extend = {24'h0, w[7:0]};
         3'b101:  extend = {16'h0, w[15:0]};
         default: extend = w;
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_of = w[7:0];
         2'd1:    byte_of = w[15:8];
         2'd2:    byte_of = w[23:16];
         default: byte_of = w[31:24];
      endcase
   endfunction

   assign rd_len  = load_len(read_i);
   assign wr_len  = store_len(write_i);
   assign cyc_nxt = cyc_q + 3'd1;
   // The byte on mem_din_i belongs to the address presented one cycle earlier.
   assign cap_idx = 2'(cyc_q - 3'd1);

   always_comb begin
      cap_word = rbuf_q;
      case (cap_idx)
         2'd0:    cap_word[7:0]   = mem_din_i;
         2'd1:    cap_word[15:8]  = mem_din_i;
         2'd2:    cap_word[23:16] = mem_din_i;
         default: cap_word[31:24] = mem_din_i;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         op_q         <= '0;
         len_q        <= '0;
         cyc_q        <= '0;
         base_q       <= '0;
         wdata_q      <= '0;
         rbuf_q       <= '0;
         read_busy_o  <= 1'b0;
         write_busy_o <= 1'b0;
         read_data_o  <= '0;
         finish_o     <= 1'b0;
         mem_a_o      <= '0;
         mem_wr_o     <= 1'b0;
         mem_dout_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cyc_q   <= '0;
               base_q  <= addr_i[ADDR_W-1:0];
               wdata_q <= wdata_i;
               // A load wins when both directions request at once.
               if (rd_len != 3'd0) begin
                  op_q        <= read_i;
                  len_q       <= rd_len;
                  rbuf_q      <= '0;
                  mem_a_o     <= addr_i[ADDR_W-1:0];
                  read_busy_o <= 1'b1;
                  state       <= READ;
               end else if (wr_len != 3'd0) begin
                  len_q        <= wr_len;
                  mem_a_o      <= addr_i[ADDR_W-1:0];
                  mem_wr_o     <= 1'b1;
                  mem_dout_o   <= wdata_i[7:0];
                  write_busy_o <= 1'b1;
                  state        <= WRITE;
               end
            end

            READ: begin
               cyc_q <= cyc_nxt;
               if (cyc_q != 3'd0)
                  rbuf_q <= cap_word;
               if (cyc_q == len_q) begin
                  read_data_o <= extend(op_q, cap_word);
                  read_busy_o <= 1'b0;
                  finish_o    <= 1'b1;
                  mem_a_o     <= '0;
                  state       <= DONE;
               end else if (cyc_nxt < len_q) begin
                  mem_a_o <= base_q + ADDR_W'(cyc_nxt);  // wraps modulo 2^ADDR_W
               end else begin
                  mem_a_o <= '0;  // waiting for the last byte to return
               end
            end

            WRITE: begin
               if (cyc_nxt < len_q) begin
                  cyc_q      <= cyc_nxt;
                  mem_a_o    <= base_q + ADDR_W'(cyc_nxt);
                  mem_dout_o <= byte_of(wdata_q, cyc_nxt[1:0]);
               end else begin
                  mem_a_o      <= '0;
                  mem_wr_o     <= 1'b0;
                  mem_dout_o   <= '0;
                  write_busy_o <= 1'b0;
                  finish_o     <= 1'b1;
                  state        <= DONE;
               end
            end

            DONE: begin
               // Any request seen here is the one just finished; ignore it.
               finish_o <= 1'b0;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed scenarios plus randomized loads/stores
// checked against a byte-array memory model and spec-level timing rules.
module tb_data_mem_ctrl;

   localparam int ADDR_W = 17;
   localparam int MASK   = (1 << ADDR_W) - 1;
   localparam int MAXC   = 16;

   logic              clk;
   logic              rst;
   logic [2:0]        read_i;
   logic [1:0]        write_i;
   logic [31:0]       addr_i;
   logic [31:0]       wdata_i;
   logic              read_busy_o;
   logic              write_busy_o;
   logic [31:0]       read_data_o;
   logic              finish_o;
   logic [ADDR_W-1:0] mem_a_o;
   logic              mem_wr_o;
   logic [7:0]        mem_dout_o;
   logic [7:0]        mem_din_i;

   data_mem_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .read_busy_o(read_busy_o),
      .write_busy_o(write_busy_o), .read_data_o(read_data_o),
      .finish_o(finish_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o),
      .mem_dout_o(mem_dout_o), .mem_din_i(mem_din_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous byte RAM; the poke port lets the bench preload contents.
   logic [7:0]        ram [0:(1<<ADDR_W)-1];
   logic              poke_en;
   logic [ADDR_W-1:0] poke_a;
   logic [7:0]        poke_d;

   always @(posedge clk) begin
      if (poke_en) ram[poke_a] <= poke_d;
      else if (mem_wr_o) ram[mem_a_o] <= mem_dout_o;
      mem_din_i <= ram[mem_a_o];
   end

   // Reference memory contents and last load result.
   logic [7:0]  shadow [int];
   logic [31:0] last_rd;

   int n_tests;
   int n_fail;

   // Per-cycle trace of one transaction, index = cycles after the accept edge.
   logic [ADDR_W-1:0] tr_a   [0:MAXC];
   logic              tr_wr  [0:MAXC];
   logic [7:0]        tr_do  [0:MAXC];
   logic              tr_rb  [0:MAXC];
   logic              tr_wb  [0:MAXC];
   logic              tr_fin [0:MAXC];
   logic [31:0]       tr_rd  [0:MAXC];
   int                fin_cyc;
   int                fin_cnt;

   function automatic int nbytes_rd(input logic [2:0] r);
      case (r)
         3'd1, 3'd4: return 1;
         3'd2, 3'd5: return 2;
         3'd3:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic int nbytes_wr(input logic [1:0] w);
      case (w)
         2'd1:    return 1;
         2'd2:    return 2;
         2'd3:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] r, input logic [31:0] a);
      logic [31:0] v;
      int n;
      v = 0;
      n = nbytes_rd(r);
      for (int k = 0; k < n; k++)
         v = v | (32'(shadow[int'((a + 32'(k)) & MASK)]) << (8 * k));
      if (r == 3'd1 && v >= 32'h80)   v = v + 32'hFFFFFF00;
      if (r == 3'd2 && v >= 32'h8000) v = v + 32'hFFFF0000;
      return v;
   endfunction

   task automatic model_store(input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
      for (int k = 0; k < nbytes_wr(w); k++)
         shadow[int'((a + 32'(k)) & MASK)] = 8'((d >> (8 * k)) & 32'hFF);
   endtask

   task automatic poke(input int a, input logic [7:0] d);
      @(negedge clk);
      poke_en = 1'b1;
      poke_a  = ADDR_W'(a);
      poke_d  = d;
      @(negedge clk);
      poke_en = 1'b0;
      shadow[a] = d;
   endtask

   // Present a request (held through the finish cycle and the one after),
   // record outputs each cycle, then drop it.
   task automatic run_op(input logic [2:0] r, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
      fin_cyc = -1;
      fin_cnt = 0;
      for (int c = 0; c <= MAXC; c++) begin
         tr_a[c] = '0; tr_wr[c] = 0; tr_do[c] = '0; tr_rb[c] = 0;
         tr_wb[c] = 0; tr_fin[c] = 0; tr_rd[c] = '0;
      end
      @(negedge clk);
      read_i = r; write_i = w; addr_i = a; wdata_i = d;
      @(posedge clk);
      for (int c = 1; c <= MAXC; c++) begin
         @(negedge clk);
         tr_a[c] = mem_a_o; tr_wr[c] = mem_wr_o; tr_do[c] = mem_dout_o;
         tr_rb[c] = read_busy_o; tr_wb[c] = write_busy_o;
         tr_fin[c] = finish_o; tr_rd[c] = read_data_o;
         if (finish_o) begin
            fin_cnt++;
            if (fin_cyc < 0) fin_cyc = c;
         end
         if (fin_cyc >= 0 && c == fin_cyc + 1) break;
      end
      read_i = 0; write_i = 0; addr_i = 0; wdata_i = 0;
   endtask

   task automatic test_reset();
      logic [ADDR_W+43:0] obs;
      @(negedge clk);
      obs = {read_busy_o, write_busy_o, finish_o, mem_wr_o, mem_a_o, mem_dout_o, read_data_o};
      n_tests++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0", obs);
      end
      rst = 1'b0;
   endtask

   task automatic test_lw();
      poke(32'h100, 8'h11); poke(32'h101, 8'h22);
      poke(32'h102, 8'h33); poke(32'h103, 8'h44);
      run_op(3'b011, 2'b00, 32'h100, 32'h0);
      for (int c = 1; c <= 4; c++) begin
         n_tests++;
         if (tr_a[c] !== ADDR_W'(32'h100 + c - 1)) begin
            n_fail++;
            $display("FAIL lw_addr c%0d: got %h want %h", c, tr_a[c], 32'h100 + c - 1);
         end
      end
      for (int c = 1; c <= 6; c++) begin
         n_tests++;
         if (tr_rb[c] !== (c <= 5) || tr_wb[c] !== 1'b0 || tr_wr[c] !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_busy c%0d: rb=%b wb=%b wr=%b want rb=%0d wb=0 wr=0",
                     c, tr_rb[c], tr_wb[c], tr_wr[c], c <= 5);
         end
      end
      n_tests++;
      if (fin_cyc != 6 || fin_cnt != 1) begin
         n_fail++;
         $display("FAIL lw_finish: cycle=%0d count=%0d want 6/1", fin_cyc, fin_cnt);
      end
      n_tests++;
      if (tr_rd[6] !== 32'h44332211) begin
         n_fail++;
         $display("FAIL lw_data: got %h want 44332211", tr_rd[6]);
      end
      last_rd = 32'h44332211;
   endtask

   task automatic test_extend();
      logic [2:0]  ops [4];
      logic [31:0] adr [4];
      logic [31:0] exp [4];
      int          lat [4];
      ops = '{3'b001, 3'b100, 3'b010, 3'b101};
      adr = '{32'h10, 32'h10, 32'h11, 32'h11};
      exp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
      lat = '{3, 3, 4, 4};
      poke(32'h10, 8'h80); poke(32'h11, 8'h01); poke(32'h12, 8'h80);
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], 2'b00, adr[i], 32'h0);
         n_tests++;
         if (fin_cyc != lat[i]) begin
            n_fail++;
            $display("FAIL ext_latency op%0d: got %0d want %0d", ops[i], fin_cyc, lat[i]);
         end
         n_tests++;
         if (fin_cyc < 1 || tr_rd[lat[i]] !== exp[i]) begin
            n_fail++;
            $display("FAIL ext_data op%0d: got %h want %h", ops[i], tr_rd[lat[i]], exp[i]);
         end
         last_rd = exp[i];
      end
   endtask

   task automatic test_sw();
      logic [31:0] prev;
      logic [7:0]  bytes [4];
      bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
      prev = last_rd;
      run_op(3'b000, 2'b11, 32'h200, 32'hDEADBEEF);
      for (int c = 1; c <= 4; c++) begin
         n_tests++;
         if (tr_wr[c] !== 1'b1 || tr_a[c] !== ADDR_W'(32'h200 + c - 1) || tr_do[c] !== bytes[c-1]) begin
            n_fail++;
            $display("FAIL sw_write c%0d: wr=%b a=%h d=%h want 1/%h/%h",
                     c, tr_wr[c], tr_a[c], tr_do[c], 32'h200 + c - 1, bytes[c-1]);
         end
      end
      for (int c = 1; c <= 5; c++) begin
         n_tests++;
         if (tr_wb[c] !== (c <= 4) || tr_rb[c] !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_busy c%0d: wb=%b rb=%b want wb=%0d rb=0", c, tr_wb[c], tr_rb[c], c <= 4);
         end
      end
      n_tests++;
      if (fin_cyc != 5 || fin_cnt != 1) begin
         n_fail++;
         $display("FAIL sw_finish: cycle=%0d count=%0d want 5/1", fin_cyc, fin_cnt);
      end
      n_tests++;
      if (tr_rd[5] !== prev) begin
         n_fail++;
         $display("FAIL sw_rdata_held: got %h want %h", tr_rd[5], prev);
      end
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (ram[32'h200 + k] !== bytes[k]) begin
            n_fail++;
            $display("FAIL sw_ram %0d: got %h want %h", k, ram[32'h200 + k], bytes[k]);
         end
      end
      model_store(2'b11, 32'h200, 32'hDEADBEEF);
   endtask

   task automatic test_wrap();
      run_op(3'b000, 2'b10, 32'h1FFFF, 32'h0000A55A);
      n_tests++;
      if (tr_a[1] !== 17'h1FFFF || tr_do[1] !== 8'h5A || tr_a[2] !== 17'h0 || tr_do[2] !== 8'hA5) begin
         n_fail++;
         $display("FAIL wrap_bus: a1=%h d1=%h a2=%h d2=%h want 1ffff/5a/00000/a5",
                  tr_a[1], tr_do[1], tr_a[2], tr_do[2]);
      end
      n_tests++;
      if (ram[17'h1FFFF] !== 8'h5A || ram[0] !== 8'hA5) begin
         n_fail++;
         $display("FAIL wrap_ram: top=%h zero=%h want 5a/a5", ram[17'h1FFFF], ram[0]);
      end
      n_tests++;
      if (fin_cyc != 3) begin
         n_fail++;
         $display("FAIL wrap_finish: got %0d want 3", fin_cyc);
      end
      model_store(2'b10, 32'h1FFFF, 32'h0000A55A);
   endtask

   task automatic test_both();
      logic [31:0] exp;
      logic        any_wr;
      for (int k = 0; k < 4; k++) poke(32'h300 + k, 8'($urandom));
      exp = model_load(3'b011, 32'h300);
      run_op(3'b011, 2'b11, 32'h300, $urandom);
      any_wr = 1'b0;
      for (int c = 1; c <= MAXC; c++) any_wr = any_wr | tr_wr[c];
      n_tests++;
      if (any_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL both_no_write: got wr seen=%b want 0", any_wr);
      end
      n_tests++;
      if (fin_cyc != 6 || fin_cnt != 1) begin
         n_fail++;
         $display("FAIL both_finish: cycle=%0d count=%0d want 6/1", fin_cyc, fin_cnt);
      end
      n_tests++;
      if (fin_cyc < 1 || tr_rd[6] !== exp) begin
         n_fail++;
         $display("FAIL both_data: got %h want %h", tr_rd[6], exp);
      end
      n_tests++;
      if (tr_rb[7] !== 1'b0 || tr_wb[7] !== 1'b0 || tr_wr[7] !== 1'b0) begin
         n_fail++;
         $display("FAIL both_after_done: rb=%b wb=%b wr=%b want 0/0/0", tr_rb[7], tr_wb[7], tr_wr[7]);
      end
      for (int k = 0; k < 4; k++) begin
         n_tests++;
         if (ram[32'h300 + k] !== shadow[32'h300 + k]) begin
            n_fail++;
            $display("FAIL both_ram %0d: got %h want %h", k, ram[32'h300 + k], shadow[32'h300 + k]);
         end
      end
      last_rd = exp;
   endtask

   task automatic test_reset_mid();
      logic [ADDR_W+43:0] obs;
      logic [31:0]        exp;
      @(negedge clk);
      read_i = 3'b011; addr_i = 32'h100;
      @(posedge clk);
      @(negedge clk);            // cycle 1
      read_i = 0; addr_i = 0;
      @(negedge clk);            // cycle 2
      @(negedge clk);            // cycle 3
      rst = 1'b1;
      @(negedge clk);            // cycle 4
      obs = {read_busy_o, write_busy_o, finish_o, mem_wr_o, mem_a_o, mem_dout_o, read_data_o};
      n_tests++;
      if (obs !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %h want 0", obs);
      end
      rst = 1'b0;
      exp = model_load(3'b001, 32'h101);
      run_op(3'b001, 2'b00, 32'h101, 32'h0);
      n_tests++;
      if (fin_cyc != 3 || fin_cnt != 1) begin
         n_fail++;
         $display("FAIL midreset_lb_finish: cycle=%0d count=%0d want 3/1", fin_cyc, fin_cnt);
      end
      n_tests++;
      if (tr_rd[3] !== exp) begin
         n_fail++;
         $display("FAIL midreset_lb_data: got %h want %h", tr_rd[3], exp);
      end
      last_rd = exp;
   endtask

   task automatic test_random();
      logic [2:0]  r;
      logic [1:0]  w;
      logic [31:0] a, low, d, exp_rd;
      int          n, exp_fin;
      bit          is_rd;
      for (int i = 32'h1FFF0; i <= 32'h1FFFF; i++) poke(i, 8'($urandom));
      for (int i = 0; i < 32; i++) poke(i, 8'($urandom));
      for (int it = 0; it < 40; it++) begin
         r   = 3'($urandom_range(0, 7));
         w   = 2'($urandom_range(1, 3));
         low = (32'h1FFF0 + $urandom_range(0, 39)) & MASK;
         a   = ($urandom & ~32'(MASK)) | low;
         d   = $urandom;
         is_rd   = nbytes_rd(r) != 0;
         n       = is_rd ? nbytes_rd(r) : nbytes_wr(w);
         exp_fin = is_rd ? n + 2 : n + 1;
         exp_rd  = is_rd ? model_load(r, a) : last_rd;
         run_op(r, w, a, d);
         n_tests++;
         if (fin_cyc != exp_fin || fin_cnt != 1) begin
            n_fail++;
            $display("FAIL rand%0d_finish r=%0d w=%0d: cycle=%0d count=%0d want %0d/1",
                     it, r, w, fin_cyc, fin_cnt, exp_fin);
         end
         n_tests++;
         if (tr_rd[exp_fin] !== exp_rd) begin
            n_fail++;
            $display("FAIL rand%0d_rdata r=%0d a=%h: got %h want %h", it, r, a, tr_rd[exp_fin], exp_rd);
         end
         for (int c = 1; c <= exp_fin; c++) begin
            n_tests++;
            if (tr_rb[c] !== (is_rd && c <= n + 1) || tr_wb[c] !== (!is_rd && c <= n)
                || tr_wr[c] !== (!is_rd && c <= n)) begin
               n_fail++;
               $display("FAIL rand%0d_ctrl c%0d: rb=%b wb=%b wr=%b", it, c, tr_rb[c], tr_wb[c], tr_wr[c]);
            end
            if (c <= n) begin
               n_tests++;
               if (tr_a[c] !== ADDR_W'((low + 32'(c) - 1) & MASK)) begin
                  n_fail++;
                  $display("FAIL rand%0d_addr c%0d: got %h want %h", it, c, tr_a[c], (low + c - 1) & MASK);
               end
            end
         end
         if (!is_rd) model_store(w, a, d);
         for (int k = 0; k < n; k++) begin
            n_tests++;
            if (ram[(low + 32'(k)) & MASK] !== shadow[int'((low + 32'(k)) & MASK)]) begin
               n_fail++;
               $display("FAIL rand%0d_ram k%0d: got %h want %h", it, k,
                        ram[(low + 32'(k)) & MASK], shadow[int'((low + 32'(k)) & MASK)]);
            end
         end
         last_rd = exp_rd;
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      last_rd = '0;
      rst     = 1'b1;
      read_i  = 0; write_i = 0; addr_i = 0; wdata_i = 0;
      poke_en = 1'b0; poke_a = '0; poke_d = '0;
      repeat (3) @(posedge clk);
      test_reset();
      test_lw();
      test_extend();
      test_sw();
      test_wrap();
      test_both();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-side responder for the CPU MEM stage's data-port request interface.
- Accepts one byte, halfword or word load/store request at a time and serialises it into byte accesses on an 8-bit synchronous RAM port.
- Returns the sign- or zero-extended load data, a busy flag per direction, and a one-cycle finish strobe.
- Sits between the MEM stage and the data RAM.

Parameters:
ADDR_W, 17, RAM byte-address width; addr_i is truncated to its ADDR_W LSBs.

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  synchronous, active-high reset
read_i  input  3  load request: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110/111 reserved (treated as none)
write_i  input  2  store request: 00 none, 01 SB, 10 SH, 11 SW
addr_i  input  32  byte address of the request
wdata_i  input  32  store data, little-endian, low bytes used for SB/SH
read_busy_o  output  1  load in progress
write_busy_o  output  1  store in progress
read_data_o  output  32  extended load result
finish_o  output  1  one-cycle completion strobe (load or store)
mem_a_o  output  ADDR_W  RAM byte address
mem_wr_o  output  1  1 = write the RAM byte this cycle
mem_dout_o  output  8  RAM write byte
mem_din_i  input  8  RAM read byte, valid the cycle after its address is presented

Behaviour:
- Reset: synchronous, active-high, as already decided.
  - All outputs are 0 and the FSM is in IDLE.
  - Reset mid-operation aborts at that edge; RAM bytes already written stay written.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - Requests are sampled only in IDLE. Let the accepting edge be E0 and N = 1, 2 or 4 bytes.
  - Latch the op, addr_i[ADDR_W-1:0] and wdata_i.
  - If read_i and write_i are both non-zero, service the read and drop the write.
- READ:
  - read_busy_o = 1.
  - mem_a_o = base+k in cycle k+1 after E0, for k = 0..N-1, with mem_wr_o = 0.
  - Byte k is captured from mem_din_i at edge E(k+2).
  - After the last capture at E(N+1), go to DONE.
- WRITE:
  - write_busy_o = 1.
  - mem_a_o = base+k, mem_dout_o = wdata byte k and mem_wr_o = 1 in cycle k+1, for k = 0..N-1.
  - Go to DONE after edge EN.
- DONE (one cycle):
  - finish_o = 1 and both busy flags = 0.
  - For loads, read_data_o carries the result.
  - Return to IDLE at the next edge. A request present during DONE is ignored, because the requester drops its request on finish.
- Latency from the accepting edge to the finish_o cycle:
  - Loads: finish_o is high in the cycle after edge E(N+1). LW = cycle 6 after E0, LB = cycle 3.
  - Stores: finish_o is high in the cycle after edge EN. SW = cycle 5, SB = cycle 2.
- Byte order is little-endian: byte k goes to bits [8k+7:8k].
- Load extension:
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW is used as-is.
- read_data_o holds its value until the next load completes. Stores do not change it.
- Address arithmetic:
  - base+k is modulo 2^ADDR_W, so access wraps from the top byte to 0.
  - No alignment check; misaligned halfwords and words are legal.
- Outside READ/WRITE: mem_a_o = 0, mem_wr_o = 0, mem_dout_o = 0.
- Busy flags are mutually exclusive. Neither busy flag is ever high in the same cycle as finish_o.

Test Plan:
1. RAM[0x100..0x103] = 11 22 33 44; LW at 0x100 -> mem_a_o 0x100..0x103 in cycles 1-4; read_busy_o high in cycles 1-5; finish_o high in cycle 6 only; read_data_o = 0x44332211.
2. RAM[0x10] = 0x80, RAM[0x11] = 0x01, RAM[0x12] = 0x80:
   - LB 0x10 -> read_data_o = 0xFFFFFF80.
   - LBU 0x10 -> 0x00000080.
   - LH 0x11 -> 0xFFFF8001.
   - LHU 0x11 -> 0x00008001.
3. SW 0xDEADBEEF at 0x200 -> bytes EF BE AD DE written to 0x200..0x203 with mem_wr_o = 1 in cycles 1-4; write_busy_o high in cycles 1-4; finish_o in cycle 5; read_data_o unchanged.
4. ADDR_W = 17, SH 0x0000A55A at 0x1FFFF -> 0x5A written at 0x1FFFF and 0xA5 at 0x00000.
5. read_i = 011 and write_i = 11 presented together, then held through DONE -> exactly one LW is serviced; no RAM write occurs; no second request is accepted in DONE.
6. rst asserted in cycle 3 of an LW -> cycle 4 shows all outputs 0; a new LB accepted afterwards completes with normal latency (finish_o in cycle 3 after its accept edge).
